// File: rtl/sm_pkg.sv
// Shared types and sign-magnitude field helpers for the accumulator.
package sm_pkg;

  typedef enum logic {ACCUM = 1'b0, RESULT = 1'b1} state_t;

  localparam int SM_MAXW     = 64;
  // The sign bit sits this many places below the operand width: index = n - SM_SIGN_OFS.
  localparam int SM_SIGN_OFS = 1;

  function automatic logic sm_sign(input logic [SM_MAXW-1:0] v, input int n);
    return 1'(v >> (n - SM_SIGN_OFS));
  endfunction

  function automatic logic [SM_MAXW-1:0] sm_mag(input logic [SM_MAXW-1:0] v, input int n);
    logic [SM_MAXW-1:0] mask;
    mask = (SM_MAXW'(1) << (n - SM_SIGN_OFS)) - SM_MAXW'(1);
    return v & mask;
  endfunction

  function automatic logic sm_is_zero(input logic [SM_MAXW-1:0] v, input int n);
    return sm_mag(v, n) == '0;
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational N-bit sign-magnitude adder; -0 operands act as +0 and the result is never -0.
// SM_ACC_SATURATE_EN: clamp magnitude to all-ones on carry instead of wrapping.
module sm_add_core
  import sm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry
);

  localparam int M = N - 1;

  logic         sa, sb, sr;
  logic [M-1:0] ma, mb, mr;
  logic [M:0]   add_full;

  assign sa = sm_sign(SM_MAXW'(a), N) & ~sm_is_zero(SM_MAXW'(a), N);
  assign sb = sm_sign(SM_MAXW'(b), N) & ~sm_is_zero(SM_MAXW'(b), N);
  assign ma = M'(sm_mag(SM_MAXW'(a), N));
  assign mb = M'(sm_mag(SM_MAXW'(b), N));
  assign add_full = {1'b0, ma} + {1'b0, mb};

  always_comb begin
    carry = 1'b0;
    mr    = '0;
    sr    = 1'b0;
    if (sa == sb) begin
      carry = add_full[M];
      mr    = add_full[M-1:0];
`ifdef SM_ACC_SATURATE_EN
      if (add_full[M]) mr = '1;
`endif
      sr    = sa;
    end else if (ma >= mb) begin
      mr = ma - mb;
      sr = sa;
    end else begin
      mr = mb - ma;
      sr = sb;
    end
    if (mr == '0) sr = 1'b0;
  end

  assign sum = {sr, mr};

endmodule

// File: rtl/sm_accumulator.sv
// Frame accumulator: sums LEN sign-magnitude operands, presents result with sticky overflow.
// SM_ACC_SATURATE_EN selects clamping (inside sm_add_core) instead of wrapping.
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_sum,
  output logic         o_ovf,
  output logic         o_valid,
  input  logic         i_ready
);

  localparam int            CW   = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t        state, state_nxt;
  logic [N-1:0]  acc, add_sum;
  logic [CW-1:0] cnt;
  logic          ovf, add_carry;
  logic          accept, release_res;

  // Clear outranks both handshakes, so it masks them here once for every consumer.
  assign accept      = (state == ACCUM)  && i_valid && !i_clear;
  assign release_res = (state == RESULT) && i_ready && !i_clear;

  sm_add_core #(.N(N)) u_add (
    .a    (acc),
    .b    (i_data),
    .sum  (add_sum),
    .carry(add_carry)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ACCUM;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && cnt == LAST) state_nxt = RESULT;
        RESULT:  if (release_res)           state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    o_ready = (state == ACCUM);
    o_valid = (state == RESULT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (i_clear || release_res) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= add_sum;
      cnt <= cnt + CW'(1);
      ovf <= ovf | add_carry;
    end
  end

  assign o_sum = acc;
  assign o_ovf = ovf;

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed, table-driven bench for sm_accumulator (N=8, LEN=4).
module tb_sm_accumulator;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_clear, i_valid, i_ready;
  logic [7:0] i_data;
  logic       o_ready, o_ovf, o_valid;
  logic [7:0] o_sum;

  int n_cmp  = 0;
  int n_fail = 0;

  sm_accumulator #(.N(8), .LEN(4)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear(i_clear),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_sum  (o_sum),
    .o_ovf  (o_ovf),
    .o_valid(o_valid),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [7:0]      sum;
    logic            ovf;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, b, c, e, s, input logic v);
    vec_t t;
    t.d[0] = a; t.d[1] = b; t.d[2] = c; t.d[3] = e;
    t.sum = s; t.ovf = v;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Present one operand, optionally after an idle cycle, and hold it until it is taken.
  task automatic send(input logic [7:0] d, input bit gap);
    int t;
    if (gap) begin
      i_valid = 1'b0;
      tick();
    end
    i_valid = 1'b1;
    i_data  = d;
    t = 0;
    while (!o_ready && t < 20) begin
      tick();
      t++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: o_ready stuck at 0, want 1");
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input vec_t v, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send(v.d[k], gap);
      if (k < 3) chk({name, "_valid_early"}, o_valid, 0);
    end
    chk({name, "_valid"}, o_valid, 1);
    chk({name, "_ready_low"}, o_ready, 0);
    chk({name, "_sum"}, o_sum, v.sum);
    chk({name, "_ovf"}, o_ovf, v.ovf);
  endtask

  task automatic consume(input string name);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({name, "_rel_ready"}, o_ready, 1);
    chk({name, "_rel_valid"}, o_valid, 0);
    chk({name, "_rel_sum"}, o_sum, 0);
    chk({name, "_rel_ovf"}, o_ovf, 0);
  endtask

  vec_t tbl [7];
  vec_t mixed;

  initial begin
    mixed  = mk(8'h05, 8'h83, 8'h0A, 8'h82, 8'h0A, 1'b0);
    tbl[0] = mixed;
`ifdef SM_ACC_SATURATE_EN
    tbl[1] = mk(8'h64, 8'h64, 8'h64, 8'h64, 8'h7F, 1'b1);
    tbl[2] = mk(8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hFF, 1'b1);
    tbl[3] = mk(8'h7F, 8'h01, 8'h00, 8'h00, 8'h7F, 1'b1);
    tbl[4] = mk(8'h7F, 8'h7F, 8'h81, 8'h00, 8'h7E, 1'b1);
`else
    tbl[1] = mk(8'h64, 8'h64, 8'h64, 8'h64, 8'h10, 1'b1);
    tbl[2] = mk(8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'h90, 1'b1);
    tbl[3] = mk(8'h7F, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
    tbl[4] = mk(8'h7F, 8'h7F, 8'h81, 8'h00, 8'h7D, 1'b1);
`endif
    tbl[5] = mk(8'h03, 8'h83, 8'h00, 8'h80, 8'h00, 1'b0);
    tbl[6] = mk(8'h81, 8'h01, 8'h81, 8'h81, 8'h82, 1'b0);

    i_rst_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    #23;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_sum",   o_sum,   0);
    chk("rst_ovf",   o_ovf,   0);
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i], 1'b0);
      consume($sformatf("vec%0d", i));
    end

    // Gapped operands must give the same result as the gap-free run.
    run_frame("gaps", mixed, 1'b1);
    consume("gaps");

    // Backpressure: result held, operands offered in RESULT are ignored.
    run_frame("bp", tbl[1], 1'b0);
    i_valid = 1'b1;
    i_data  = 8'h7F;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", o_valid, 1);
      chk("bp_ready", o_ready, 0);
      chk("bp_sum",   o_sum,   tbl[1].sum);
      chk("bp_ovf",   o_ovf,   1);
    end
    i_valid = 1'b0;
    consume("bp");
    run_frame("after_bp", mixed, 1'b0);
    consume("after_bp");

    // Clear mid-frame, with an operand in the same cycle that must be dropped.
    send(8'h7F, 1'b0);
    send(8'h01, 1'b0);
    chk("pre_clr_ovf", o_ovf, 1);
    i_clear = 1'b1; i_valid = 1'b1; i_data = 8'h22;
    tick();
    i_clear = 1'b0; i_valid = 1'b0;
    chk("clr_sum",   o_sum,   0);
    chk("clr_ovf",   o_ovf,   0);
    chk("clr_ready", o_ready, 1);
    chk("clr_valid", o_valid, 0);
    run_frame("after_clr", mixed, 1'b0);

    // Clear while a result is waiting discards it, even with i_ready high.
    i_clear = 1'b1; i_ready = 1'b1;
    tick();
    i_clear = 1'b0; i_ready = 1'b0;
    chk("clr_res_valid", o_valid, 0);
    chk("clr_res_ready", o_ready, 1);
    chk("clr_res_sum",   o_sum,   0);
    run_frame("after_clr_res", tbl[6], 1'b0);
    consume("after_clr_res");

    // Asynchronous reset pulse between clock edges, mid-frame.
    send(8'h64, 1'b0);
    send(8'h64, 1'b0);
    #2 i_rst_n = 1'b0;
    #2;
    chk("arst_sum",   o_sum,   0);
    chk("arst_ovf",   o_ovf,   0);
    chk("arst_ready", o_ready, 1);
    chk("arst_valid", o_valid, 0);
    #1 i_rst_n = 1'b1;
    tick();
    run_frame("after_arst", mixed, 1'b0);
    consume("after_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
